// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder slice.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for serial_adder_ctrl; the ovf wire exists only when
// SERIAL_ADD_OVF_EN is defined.
import serial_adder_pkg::*;

interface serial_adder_ctrl_if #(parameter int WIDTH = DEFAULT_WIDTH);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum, cout, ovf);
`else
    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum, cout);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum, cout);
`endif

endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell; purely combinational, its clk pin is only there so
// the cell drops into clocked slices with a uniform footprint.
module full_adder (
    input  logic clk,
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic unused_clk;
    assign unused_clk = clk;

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder driving a single full_adder cell, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow flag.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_cell (
        .clk (clk),
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .ci  (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    // DONE accepts a new start just like IDLE so back-to-back adds lose no cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg    <= bus.a_in;
                        b_reg    <= bus.b_in;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        state    <= IDLE;
                    end
                end
                SHIFT: begin
                    sum_reg <= {fa_s, sum_reg[WIDTH-1:1]};
                    carry   <= fa_co;
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.sum  <= {fa_s, sum_reg[WIDTH-1:1]};
                        bus.cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // Carry into the MSB differing from carry out means signed overflow.
                        bus.ovf  <= carry ^ fa_co;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised self-checking bench for serial_adder_ctrl against a plain
// arithmetic reference; ovf is checked when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int W       = 8;
    localparam int TIMEOUT = 4 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectorCount = 0;
    int   failCount   = 0;
    int   cycles;
    int   busyCycles;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W:0] refAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic refOvf(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Presents operands with start and returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic runToDone(input int lockoutAt, input bit holdStart);
        cycles     = 0;
        busyCycles = 0;
        while (!bus.done && cycles < TIMEOUT) begin
            if (bus.busy) busyCycles++;
            if (!holdStart) begin
                bus.start = (cycles == lockoutAt);
                if (bus.start) begin
                    bus.a_in = 8'hAA;
                    bus.b_in = 8'h55;
                    bus.cin  = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!holdStart) bus.start = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic c);
        logic [W:0] exp;
        exp = refAdd(a, b, c);
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(W));
        checkOutput({tag, ".busy_cycles"}, 32'(busyCycles), 32'(W));
        checkOutput({tag, ".done"}, 32'(bus.done), 32'(1));
        checkOutput({tag, ".sum"}, 32'(bus.sum), 32'(exp[W-1:0]));
        checkOutput({tag, ".cout"}, 32'(bus.cout), 32'(exp[W]));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(refOvf(a, b, exp[W-1:0])));
`endif
    endtask

    task automatic idleCheck(input int n, input string tag);
        logic [W-1:0] heldSum;
        logic         heldCout;
        int           pulses;
        heldSum  = bus.sum;
        heldCout = bus.cout;
        pulses   = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        checkOutput({tag, ".extra_done"}, 32'(pulses), 32'(0));
        checkOutput({tag, ".sum_held"}, 32'(bus.sum), 32'(heldSum));
        checkOutput({tag, ".cout_held"}, 32'(bus.cout), 32'(heldCout));
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c, input int lockoutAt);
        launch(a, b, c);
        bus.start = 1'b0;
        bus.a_in  = W'($urandom);
        bus.b_in  = W'($urandom);
        bus.cin   = 1'($urandom);
        runToDone(lockoutAt, 1'b0);
        checkResult(tag, a, b, c);
        idleCheck((lockoutAt >= 0) ? W + 2 : 1, tag);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(bus.busy), 32'(0));
        checkOutput("reset.done", 32'(bus.done), 32'(0));
        checkOutput("reset.sum", 32'(bus.sum), 32'(0));
        checkOutput("reset.cout", 32'(bus.cout), 32'(0));
        rst = 1'b0;

        applyStimulus("basic", 8'h3C, 8'h45, 1'b0, -1);
        applyStimulus("ripple1", 8'hFF, 8'h01, 1'b0, -1);
        applyStimulus("ripple2", 8'hFF, 8'hFF, 1'b1, -1);
        applyStimulus("lockout", 8'h10, 8'h20, 1'b0, 2);
        applyStimulus("ovf_pos", 8'h7F, 8'h01, 1'b0, -1);
        applyStimulus("ovf_neg", 8'h80, 8'h80, 1'b0, -1);
        applyStimulus("ovf_none", 8'h10, 8'h20, 1'b0, -1);

        // Start held high across DONE: the second operand pair enters with no gap.
        launch(8'h01, 8'h02, 1'b0);
        bus.a_in = 8'h05;
        bus.b_in = 8'h06;
        runToDone(-1, 1'b1);
        checkResult("b2b_first", 8'h01, 8'h02, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        runToDone(-1, 1'b0);
        checkResult("b2b_second", 8'h05, 8'h06, 1'b0);
        idleCheck(1, "b2b_second");

        launch(8'h7E, 8'h7E, 1'b0);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        checkOutput("abort.busy", 32'(bus.busy), 32'(0));
        checkOutput("abort.done", 32'(bus.done), 32'(0));
        checkOutput("abort.sum", 32'(bus.sum), 32'(0));
        checkOutput("abort.cout", 32'(bus.cout), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("abort.ovf", 32'(bus.ovf), 32'(0));
`endif
        idleCheck(W + 3, "abort");

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            int           lock;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : -1;
            applyStimulus($sformatf("rand%0d", i), ra, rb, rc, lock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell. It sits directly upstream of, and drives, that cell:
- Latches two operands on start.
- Feeds one bit pair per clock, LSB first, into the cell.
- Captures each sum bit into a shift register.
- Recirculates the cell's carry through a flip-flop.

It trades WIDTH+1 cycles of latency for one adder cell and is the sequential companion to the combinational adder exercises.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on clk.
- a_in  input  WIDTH  operand A, sampled when start is accepted.
- b_in  input  WIDTH  operand B, sampled when start is accepted.
- cin  input  1  initial carry, sampled when start is accepted.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result, held stable until the next accepted start.
- cout  output  1  final carry, held with sum.
- ovf  output  1  signed overflow (only with SERIAL_ADD_OVF_EN).

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values:
  - State IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand registers, carry flop and bit counter all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, latch a_in→A_reg, b_in→B_reg, cin→carry, clear bit counter, go to SHIFT.
  - sum and cout keep their previous values.
- SHIFT (busy=1), each cycle:
  - Drive the cell with A_reg[0], B_reg[0], carry.
  - Shift the cell's s into sum_reg from the MSB side (shift right).
  - Register the cell's cout into carry.
  - Shift A_reg and B_reg right by one.
  - Increment the counter.
  - On the cycle the counter reaches WIDTH-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - sum = sum_reg; cout = final carry.
  - Return to IDLE.
  - A start seen in DONE is accepted exactly as in IDLE (back-to-back operation, no dead cycle).
- Latency: start accepted at edge N; done high in the cycle after edge N+WIDTH. That is WIDTH SHIFT cycles plus one DONE cycle.
- start while busy=1 is ignored; operands are not re-sampled.
- Cell outputs are consumed combinationally in the same cycle as its inputs; no pipeline stage inside the slice.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry-out exported on cout.
- rst during SHIFT or DONE aborts immediately: next cycle is IDLE with all outputs at reset values; no done pulse.
- rst and start high together: rst wins; start is dropped.
- Bit counter width is clog2(WIDTH). It never wraps past WIDTH-1 because the FSM leaves SHIFT first.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds port ovf.
  - During the last SHIFT cycle, the carry into the MSB slice (the carry flop value) is XORed with the cell's cout and registered.
  - ovf is valid with done and held with sum; it is cleared by rst.
- Undefined: port ovf and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module: one instance of the existing one-bit full_adder cell. Its clk port is tied to clk.
- FSM, shift registers, counter and carry flop live in serial_adder_ctrl.

Test Plan (WIDTH=8):
- Basic add: 0x3C + 0x45, cin=0 → sum=0x81, cout=0, done pulses exactly 9 cycles after start, busy high 8 cycles.
- Carry ripple: 0xFF + 0x01, cin=0 → sum=0x00, cout=1; then 0xFF + 0xFF, cin=1 → sum=0xFF, cout=1.
- Busy lock-out: start 0x10 + 0x20, pulse start with 0xAA/0x55 at cycle 3 → result 0x30, only one done pulse.
- Back-to-back: start 0x01 + 0x02 held high through the DONE cycle with new operands 0x05 + 0x06 → done with 0x03, then done with 0x0B.
- Reset mid-op: start 0x7E + 0x7E, rst high at cycle 4 → next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse afterwards.
- With SERIAL_ADD_OVF_EN:
  - 0x7F + 0x01 → sum=0x80, ovf=1, cout=0.
  - 0x80 + 0x80 → sum=0x00, ovf=1, cout=1.
  - 0x10 + 0x20 → ovf=0.
